// File: rtl/edu_tpu_wb_loader.sv
// Wishbone job sequencer for the edu TPU: streams weight and input words from a
// 4-entry load buffer to BASE_ADDRESS, waits DRAIN cycles, then reads back results.
module edu_tpu_wb_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N_WGT        = 3,
  parameter int          N_IN         = 6,
  parameter int          N_OUT        = 5,
  parameter int          DRAIN        = 40,
  parameter int          TMO          = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [2:0]  res_idx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [2:0]  dbg_state
);

  localparam int DW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_W, S_WR_I, S_DRAIN, S_RD, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t          state;
  state_t          ret_state;
  logic [3:0]      word_cnt;
  logic [7:0]      tmo_cnt;
  logic [DW-1:0]   drain_cnt;

  // Load buffer: a word is taken on any cycle where ld_valid && ld_ready.
  logic [31:0] mem [0:3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;
  logic        fifo_empty;

  assign ld_ready   = (count != 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign push       = ld_valid && ld_ready;
  assign pop        = wbm_stb_o && wbm_ack_i && wbm_we_o &&
                      ((state == S_WR_W) || (state == S_WR_I));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      word_cnt  <= 4'd0;
      tmo_cnt   <= 8'd0;
      drain_cnt <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      res_valid <= 1'b0;
      res_data  <= 32'h0;
      res_idx   <= 3'd0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WR_W;
            word_cnt  <= 4'd0;
            tmo_cnt   <= 8'd0;
            drain_cnt <= '0;
          end
        end
        S_WR_W, S_WR_I: begin
          // An ack only counts while strobe is up; a lingering ack is ignored.
          if (!wbm_stb_o) begin
            if (!fifo_empty) begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_adr_o <= BASE_ADDRESS;
              wbm_dat_o <= mem[rd_ptr];
              tmo_cnt   <= 8'd0;
            end
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            tmo_cnt   <= 8'd0;
            state     <= S_GAP;
            if (state == S_WR_W) begin
              if (word_cnt == 4'(N_WGT - 1)) begin
                word_cnt  <= 4'd0;
                ret_state <= S_WR_I;
              end else begin
                word_cnt  <= word_cnt + 4'd1;
                ret_state <= S_WR_W;
              end
            end else begin
              if (word_cnt == 4'(N_IN - 1)) begin
                word_cnt  <= 4'd0;
                drain_cnt <= '0;
                ret_state <= S_DRAIN;
              end else begin
                word_cnt  <= word_cnt + 4'd1;
                ret_state <= S_WR_I;
              end
            end
          end else if (tmo_cnt == 8'(TMO - 1)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN - 1)) state <= S_RD;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        S_RD: begin
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= BASE_ADDRESS;
            tmo_cnt   <= 8'd0;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            tmo_cnt   <= 8'd0;
            res_valid <= 1'b1;
            res_data  <= wbm_dat_i;
            res_idx   <= word_cnt[2:0];
            state     <= S_GAP;
            if (word_cnt == 4'(N_OUT - 1)) begin
              ret_state <= S_DONE;
            end else begin
              word_cnt  <= word_cnt + 4'd1;
              ret_state <= S_RD;
            end
          end else if (tmo_cnt == 8'(TMO - 1)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_GAP:   state <= ret_state;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
